// File: rtl/hwag_core.sv
// hwag_core: crank angle generator for a 60-2 trigger wheel.
// Conditions the VR tooth input, locks onto the missing-tooth gap,
// interpolates 64 angle ticks per tooth and drives one ignition coil.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_HUNT | not locked; waiting for a qualified gap edge
//   S_SYNC | locked; tooth counter and angle interpolation are valid
module hwag_core #(
   parameter int FILTER_LEN  = 3,
   parameter int CAP_MIN     = 128,
   parameter int CAP_MAX     = 65535,
   parameter int TOOTH_LAST  = 57,
   parameter int START_TEETH = 4,
   parameter int GAP_RATIO   = 2,
   parameter int ANGLE_TOP   = 3839,
   parameter int IGN_CHARGE  = 1024,
   parameter int IGN_ANGLE   = 3830
) (
   input  logic clk,
   input  logic rst,
   input  logic cap_in,
   output logic cap_out,
   output logic led1_out,
   output logic led2_out,
   output logic coil14_out
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int SW = $clog2(START_TEETH + 1);

   localparam logic [FW-1:0] C_FLT_LAST   = FW'(FILTER_LEN - 1);
   localparam logic [SW-1:0] C_START      = SW'(START_TEETH);
   localparam logic [15:0]   C_CAP_MIN    = 16'(CAP_MIN);
   localparam logic [15:0]   C_CAP_MAX    = 16'(CAP_MAX);
   localparam logic [17:0]   C_RATIO      = 18'(GAP_RATIO);
   localparam logic [5:0]    C_TOOTH_LAST = 6'(TOOTH_LAST);
   localparam logic [11:0]   C_ANGLE_TOP  = 12'(ANGLE_TOP);
   localparam logic [11:0]   C_IGN_END    = 12'(IGN_ANGLE);

   // Dwell window start; a negative start wraps into the previous revolution.
   localparam int  WIN_START_RAW = IGN_ANGLE - IGN_CHARGE;
   localparam bit  WIN_WRAP      = (WIN_START_RAW < 0);
   localparam int  WIN_START     = WIN_WRAP ? (WIN_START_RAW + ANGLE_TOP + 1) : WIN_START_RAW;
   localparam logic [11:0] C_WIN_START = 12'(WIN_START);

   typedef enum logic {S_HUNT = 1'b0, S_SYNC = 1'b1} state_t;

   // input conditioning
   logic          r_sync1, r_sync2;
   logic [FW-1:0] r_flt_cnt;
   logic          r_cap, r_cap_d;

   // period measurement
   logic [15:0]   r_cnt;
   logic [15:0]   r_prev_period;
   logic          r_ref_valid;
   logic          r_last_gap;
   logic [SW-1:0] r_norm_cnt;

   // sync / angle / outputs
   state_t        r_state;
   logic [5:0]    r_tooth;
   logic [11:0]   r_angle;
   logic [9:0]    r_tick;
   logic          r_led1, r_led2, r_coil;

   logic          w_edge, w_acc, w_gap, w_norm, w_stall;
   logic [17:0]   w_gap_thr;
   logic [9:0]    w_subtick;
   logic          w_tick_done;
   logic          w_tooth_last;
   logic [11:0]   w_angle_lim;
   logic [11:0]   w_next_base;
   logic          w_in_win;

   assign w_edge       = r_cap & ~r_cap_d;
   assign w_acc        = w_edge && (r_cnt >= C_CAP_MIN);
   assign w_gap_thr    = C_RATIO * {2'b00, r_prev_period};
   // The first accepted edge after reset or stall only starts the period count.
   assign w_gap        = w_acc && r_ref_valid && !r_last_gap && (r_norm_cnt == C_START)
                         && ({2'b00, r_cnt} >= w_gap_thr);
   assign w_norm       = w_acc && r_ref_valid && !w_gap;
   // A coinciding edge takes precedence over the stall.
   assign w_stall      = (r_cnt == C_CAP_MAX) && !w_acc;

   assign w_subtick    = r_prev_period[15:6];
   assign w_tick_done  = ({1'b0, r_tick} + 11'd1) >= {1'b0, w_subtick};
   assign w_tooth_last = (r_tooth == C_TOOTH_LAST);
   // The last tooth stretches across the gap up to the end of the revolution.
   assign w_angle_lim  = w_tooth_last ? C_ANGLE_TOP : {r_tooth, 6'h3F};
   assign w_next_base  = {r_tooth + 6'd1, 6'd0};
   assign w_in_win     = WIN_WRAP ? ((r_angle >= C_WIN_START) || (r_angle < C_IGN_END))
                                  : ((r_angle >= C_WIN_START) && (r_angle < C_IGN_END));

   // Synchronize the raw VR input and debounce it into cap_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_flt_cnt <= '0;
         r_cap     <= 1'b0;
         r_cap_d   <= 1'b0;
      end else begin
         r_sync1 <= cap_in;
         r_sync2 <= r_sync1;
         r_cap_d <= r_cap;
         if (r_sync2 == r_cap) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == C_FLT_LAST) begin
            r_cap     <= r_sync2;
            r_flt_cnt <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end
      end
   end

   // Measure tooth periods and qualify gap edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt         <= '0;
         r_prev_period <= '0;
         r_ref_valid   <= 1'b0;
         r_last_gap    <= 1'b0;
         r_norm_cnt    <= '0;
      end else if (w_acc) begin
         r_cnt       <= 16'd1;
         r_ref_valid <= 1'b1;
         r_last_gap  <= w_gap;
         if (w_norm) begin
            r_prev_period <= r_cnt;
            if (r_norm_cnt != C_START)
               r_norm_cnt <= r_norm_cnt + 1'b1;
         end
      end else begin
         if (r_cnt != C_CAP_MAX)
            r_cnt <= r_cnt + 16'd1;
         if (w_stall) begin
            r_ref_valid <= 1'b0;
            r_last_gap  <= 1'b0;
            r_norm_cnt  <= '0;
         end
      end
   end

   // Sync state machine with tooth tracking, angle interpolation and coil drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_HUNT;
         r_tooth <= '0;
         r_angle <= '0;
         r_tick  <= '0;
         r_led1  <= 1'b0;
         r_led2  <= 1'b0;
         r_coil  <= 1'b0;
      end else begin
         case (r_state)
            S_HUNT: begin
               r_coil <= 1'b0;
               if (w_gap) begin
                  r_state <= S_SYNC;
                  r_tooth <= '0;
                  r_angle <= '0;
                  r_tick  <= '0;
                  r_led1  <= 1'b1;
                  r_led2  <= ~r_led2;
               end else if (w_stall) begin
                  r_tooth <= '0;
               end
            end
            S_SYNC: begin
               r_coil <= w_in_win;
               if (w_gap) begin
                  if (w_tooth_last) begin
                     r_tooth <= '0;
                     r_angle <= '0;
                     r_tick  <= '0;
                     r_led2  <= ~r_led2;
                  end else begin
                     r_state <= S_HUNT;
                     r_led1  <= 1'b0;
                     r_coil  <= 1'b0;
                  end
               end else if (w_norm) begin
                  if (w_tooth_last) begin
                     r_state <= S_HUNT;
                     r_led1  <= 1'b0;
                     r_coil  <= 1'b0;
                  end else begin
                     r_tooth <= r_tooth + 6'd1;
                     r_angle <= w_next_base;
                     r_tick  <= '0;
                  end
               end else if (w_stall) begin
                  r_state <= S_HUNT;
                  r_tooth <= '0;
                  r_led1  <= 1'b0;
                  r_coil  <= 1'b0;
               end else if (w_tick_done) begin
                  r_tick <= '0;
                  if (r_angle < w_angle_lim)
                     r_angle <= r_angle + 12'd1;
               end else begin
                  r_tick <= r_tick + 10'd1;
               end
            end
            default: r_state <= S_HUNT;
         endcase
      end
   end

   assign cap_out    = r_cap;
   assign led1_out   = r_led1;
   assign led2_out   = r_led2;
   assign coil14_out = r_coil;

endmodule

// File: tb/tb_hwag_core.sv
// Directed bench for hwag_core: filter, lock, interpolation, coil window,
// gap/short-edge/stall faults and asynchronous reset.
module tb_hwag_core;

   logic clk = 1'b0;
   logic rst;
   logic cap_in;
   logic cap_out, led1_out, led2_out, coil14_out;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int last_rise = 0;
   int coil_rises = 0, coil_rise_cyc = 0, coil_fall_cyc = 0;
   logic prev_coil = 1'b0;
   logic exp_led2  = 1'b0;
   logic seen_high;
   int r43 = 0, r57 = 0;

   // A short stall limit keeps the stall scenario brief.
   hwag_core #(.CAP_MAX(4095)) dut (
      .clk        (clk),
      .rst        (rst),
      .cap_in     (cap_in),
      .cap_out    (cap_out),
      .led1_out   (led1_out),
      .led2_out   (led2_out),
      .coil14_out (coil14_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; bookkeeping of coil edges 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (coil14_out && !prev_coil) begin
         coil_rises++;
         coil_rise_cyc = cyc;
      end
      if (!coil14_out && prev_coil)
         coil_fall_cyc = cyc;
      prev_coil = coil14_out;
   endtask

   // Tooth whose rising edge comes p clocks after the previous one; 8-clock high pulse.
   task automatic pulse_after(input int p);
      repeat (p - 8) tick();
      cap_in    = 1'b1;
      last_rise = cyc;
      repeat (8) tick();
      cap_in = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      cap_in = 1'b0;
      repeat (3) tick();
      chk("rst_cap_out", 32'(cap_out), 32'd0);
      chk("rst_led1",    32'(led1_out), 32'd0);
      chk("rst_led2",    32'(led2_out), 32'd0);
      chk("rst_coil",    32'(coil14_out), 32'd0);
      rst = 1'b0;
      tick();

      // glitch filter
      seen_high = cap_out;
      cap_in = 1'b1;
      repeat (2) tick();
      cap_in = 1'b0;
      repeat (10) begin
         tick();
         seen_high = seen_high | cap_out;
      end
      chk("flt_short_pulse", 32'(seen_high), 32'd0);
      cap_in = 1'b1;
      repeat (4) tick();
      chk("flt_lat4", 32'(cap_out), 32'd0);
      tick();
      chk("flt_lat5", 32'(cap_out), 32'd1);
      repeat (5) tick();
      cap_in = 1'b0;
      repeat (10) tick();

      // lock on a clean wheel
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      pulse_after(300);
      repeat (10) pulse_after(256);
      chk("hunt_before_gap", 32'(led1_out), 32'd0);
      pulse_after(768);
      exp_led2 = ~exp_led2;
      chk("lock_led1", 32'(led1_out), 32'd1);
      chk("lock_led2", 32'(led2_out), 32'(exp_led2));

      for (int rev = 0; rev < 3; rev++) begin
         coil_rises = 0;
         for (int t = 1; t <= 57; t++) begin
            pulse_after(256);
            if (t == 43) r43 = last_rise;
            if (t == 57) r57 = last_rise;
            if (rev == 0 && t == 10) chk("angle_tooth10", 32'(dut.r_angle), 32'd640);
         end
         pulse_after(768);
         exp_led2 = ~exp_led2;
         chk("rev_led1", 32'(led1_out), 32'd1);
         chk("rev_led2", 32'(led2_out), 32'(exp_led2));
         chk("coil_rises", 32'(coil_rises), 32'd1);
         chk("coil_rise_cyc", 32'(coil_rise_cyc), 32'(r43 + 223));
         chk("coil_fall_cyc", 32'(coil_fall_cyc), 32'(r57 + 735));
      end

      // angle holds at the tooth limit when the next edge is late
      repeat (10) pulse_after(256);
      chk("angle_tooth10_b", 32'(dut.r_angle), 32'd640);
      repeat (580) tick();
      chk("angle_hold", 32'(dut.r_angle), 32'd703);
      repeat (12) tick();
      cap_in = 1'b1;
      repeat (8) tick();
      cap_in = 1'b0;
      chk("late_edge_led1", 32'(led1_out), 32'd0);
      chk("late_edge_coil", 32'(coil14_out), 32'd0);

      // relock, then a short noise edge
      pulse_after(256);
      pulse_after(768);
      exp_led2 = ~exp_led2;
      chk("relock1_led1", 32'(led1_out), 32'd1);
      chk("relock1_led2", 32'(led2_out), 32'(exp_led2));
      repeat (5) pulse_after(256);
      chk("tooth5", 32'(dut.r_tooth), 32'd5);
      pulse_after(100);
      chk("noise_tooth", 32'(dut.r_tooth), 32'd5);
      chk("noise_led1", 32'(led1_out), 32'd1);
      pulse_after(156);
      chk("tooth6", 32'(dut.r_tooth), 32'd6);

      // early gap after 40 teeth
      repeat (34) pulse_after(256);
      chk("tooth40", 32'(dut.r_tooth), 32'd40);
      pulse_after(768);
      chk("early_gap_led1", 32'(led1_out), 32'd0);
      chk("early_gap_coil", 32'(coil14_out), 32'd0);
      chk("early_gap_led2", 32'(led2_out), 32'(exp_led2));
      pulse_after(256);
      pulse_after(768);
      exp_led2 = ~exp_led2;
      chk("relock2_led1", 32'(led1_out), 32'd1);
      chk("relock2_led2", 32'(led2_out), 32'(exp_led2));

      // stall: input stops
      repeat (3900) tick();
      chk("pre_stall_led1", 32'(led1_out), 32'd1);
      repeat (300) tick();
      chk("stall_led1", 32'(led1_out), 32'd0);
      chk("stall_tooth", 32'(dut.r_tooth), 32'd0);
      chk("stall_coil", 32'(coil14_out), 32'd0);

      // recover, then reset mid-operation
      pulse_after(300);
      repeat (5) pulse_after(256);
      pulse_after(768);
      exp_led2 = ~exp_led2;
      chk("relock3_led1", 32'(led1_out), 32'd1);
      chk("relock3_led2", 32'(led2_out), 32'(exp_led2));
      chk("pre_rst_cap_out", 32'(cap_out), 32'd1);
      rst = 1'b1;
      #1;
      exp_led2 = 1'b0;
      chk("mid_rst_cap_out", 32'(cap_out), 32'd0);
      chk("mid_rst_led1", 32'(led1_out), 32'd0);
      chk("mid_rst_led2", 32'(led2_out), 32'(exp_led2));
      chk("mid_rst_coil", 32'(coil14_out), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      pulse_after(300);
      repeat (3) pulse_after(256);
      pulse_after(768);
      chk("start_teeth_short", 32'(led1_out), 32'd0);
      pulse_after(256);
      pulse_after(768);
      exp_led2 = ~exp_led2;
      chk("start_teeth_lock", 32'(led1_out), 32'd1);
      chk("start_teeth_led2", 32'(led2_out), 32'(exp_led2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
